// File: rtl/local_eject_arbiter.sv
// local_eject_arbiter: merges dx==0 packets from the east and west links into
// the local output port through a DEPTH-entry FIFO. Round-robin arbitration
// picks one link per cycle; packets with dx != 0 are consumed, dropped and
// flagged on misroute_err one cycle later.
// Optional feature: define EJECT_STATS_EN to add saturating 16-bit counters
// eject_cnt_east, eject_cnt_west and drop_cnt.
module local_eject_arbiter #(
    parameter int PKT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PKT_W-1:0]           packet_east_in,
    input  logic                       valid_east_in,
    output logic                       ready_east_out,
    input  logic [PKT_W-1:0]           packet_west_in,
    input  logic                       valid_west_in,
    output logic                       ready_west_out,
    output logic [PKT_W-1:0]           packet_local,
    output logic                       valid_local,
    input  logic                       ready_local,
    output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef EJECT_STATS_EN
    output logic [15:0]                eject_cnt_east,
    output logic [15:0]                eject_cnt_west,
    output logic [15:0]                drop_cnt,
`endif
    output logic                       misroute_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Saturating increment used by the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             prio_east;
    logic             misroute_p1;

    logic             full;
    logic             grant_east;
    logic             grant_west;
    logic             xfer_east;
    logic             xfer_west;
    logic             xfer_any;
    logic [PKT_W-1:0] sel_pkt_p0;
    logic signed [3:0] sel_dx_p0;
    logic             wr_en;
    logic             drop_p0;
    logic             pop;

    // Arbitration, handshake and push/pop decisions from registered state.
    always_comb begin
        full       = (count == CW'(DEPTH));
        grant_east = valid_east_in && (!valid_west_in || prio_east);
        grant_west = valid_west_in && (!valid_east_in || !prio_east);
        xfer_east  = grant_east && !full;
        xfer_west  = grant_west && !full;
        xfer_any   = xfer_east || xfer_west;
        sel_pkt_p0 = xfer_east ? packet_east_in : packet_west_in;
        sel_dx_p0  = sel_pkt_p0[PKT_W-1 -: 4];
        wr_en      = xfer_any && (sel_dx_p0 == 4'sd0);
        drop_p0    = xfer_any && (sel_dx_p0 != 4'sd0);
        pop        = (count != '0) && ready_local;
    end

    assign ready_east_out = xfer_east;
    assign ready_west_out = xfer_west;
    assign valid_local    = (count != '0);
    assign packet_local   = valid_local ? mem[rd_ptr] : '0;
    assign fifo_count     = count;
    assign misroute_err   = misroute_p1;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sel_pkt_p0;
    end

    // Control state: pointers, occupancy, round-robin priority, drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            prio_east   <= 1'b1;
            misroute_p1 <= 1'b0;
        end else begin
            misroute_p1 <= drop_p0;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (xfer_east)      prio_east <= 1'b0;
            else if (xfer_west) prio_east <= 1'b1;
        end
    end

`ifdef EJECT_STATS_EN
    // Saturating statistics: packets written per link and misrouted drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eject_cnt_east <= '0;
            eject_cnt_west <= '0;
            drop_cnt       <= '0;
        end else begin
            if (wr_en && xfer_east) eject_cnt_east <= sat_inc(eject_cnt_east);
            if (wr_en && xfer_west) eject_cnt_west <= sat_inc(eject_cnt_west);
            if (drop_p0)            drop_cnt       <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_local_eject_arbiter.sv
// Testbench for local_eject_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_local_eject_arbiter;

    localparam int PKT_W = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PKT_W-1:0]  packet_east_in;
    logic              valid_east_in;
    logic              ready_east_out;
    logic [PKT_W-1:0]  packet_west_in;
    logic              valid_west_in;
    logic              ready_west_out;
    logic [PKT_W-1:0]  packet_local;
    logic              valid_local;
    logic              ready_local;
    logic [2:0]        fifo_count;
    logic              misroute_err;
`ifdef EJECT_STATS_EN
    logic [15:0]       eject_cnt_east;
    logic [15:0]       eject_cnt_west;
    logic [15:0]       drop_cnt;
`endif

    always #5 clk = ~clk;

    local_eject_arbiter #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .packet_east_in (packet_east_in),
        .valid_east_in  (valid_east_in),
        .ready_east_out (ready_east_out),
        .packet_west_in (packet_west_in),
        .valid_west_in  (valid_west_in),
        .ready_west_out (ready_west_out),
        .packet_local   (packet_local),
        .valid_local    (valid_local),
        .ready_local    (ready_local),
        .fifo_count     (fifo_count),
`ifdef EJECT_STATS_EN
        .eject_cnt_east (eject_cnt_east),
        .eject_cnt_west (eject_cnt_west),
        .drop_cnt       (drop_cnt),
`endif
        .misroute_err   (misroute_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [PKT_W-1:0] mq[$];
    bit  m_prio_east;
    bit  m_mis;
    int  m_ec, m_wc, m_dc;
    bit  exp_re, exp_rw;
    bit  last_xe, last_xw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prio_east = 1'b1;
        m_mis = 1'b0;
        m_ec = 0; m_wc = 0; m_dc = 0;
        last_xe = 1'b0; last_xw = 1'b0;
    endtask

    // Mid-cycle: derive expected outputs from the model and compare.
    task automatic cyc_begin();
        bit full;
        logic [PKT_W-1:0] head;
        @(negedge clk);
        full   = (mq.size() == DEPTH);
        exp_re = valid_east_in && (!valid_west_in || m_prio_east) && !full;
        exp_rw = valid_west_in && (!valid_east_in || !m_prio_east) && !full;
        head   = (mq.size() != 0) ? mq[0] : '0;
        chk("ready_east", ready_east_out, exp_re);
        chk("ready_west", ready_west_out, exp_rw);
        chk("valid_local", valid_local, mq.size() != 0);
        chk("packet_local", packet_local, head);
        chk("fifo_count", fifo_count, mq.size());
        chk("misroute_err", misroute_err, m_mis);
`ifdef EJECT_STATS_EN
        chk("eject_cnt_east", eject_cnt_east, m_ec);
        chk("eject_cnt_west", eject_cnt_west, m_wc);
        chk("drop_cnt", drop_cnt, m_dc);
`endif
    endtask

    // Advance the model by one clock using the model's own ready decisions.
    task automatic cyc_end();
        logic [PKT_W-1:0] p;
        bit pop;
        pop = (mq.size() != 0) && ready_local;
        last_xe = valid_east_in && exp_re;
        last_xw = valid_west_in && exp_rw;
        if (pop) void'(mq.pop_front());
        m_mis = 1'b0;
        if (last_xe || last_xw) begin
            p = last_xe ? packet_east_in : packet_west_in;
            if (p[15:12] == 4'h0) begin
                mq.push_back(p);
                if (last_xe) m_ec = (m_ec < 65535) ? m_ec + 1 : m_ec;
                else         m_wc = (m_wc < 65535) ? m_wc + 1 : m_wc;
            end else begin
                m_mis = 1'b1;
                m_dc = (m_dc < 65535) ? m_dc + 1 : m_dc;
            end
            m_prio_east = last_xw;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_east_in = 1'b0; valid_west_in = 1'b0;
        packet_east_in = '0; packet_west_in = '0;
        ready_local = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [PKT_W-1:0] p;
        p = PKT_W'($urandom);
        if ($urandom_range(0, 5) != 0) p[15:12] = 4'h0;
        return p;
    endfunction

    initial begin
        rst_n = 1'b0;
        valid_east_in = 1'b0; valid_west_in = 1'b0;
        packet_east_in = '0; packet_west_in = '0;
        ready_local = 1'b0;

        // Reset state and single east packet
        do_reset();
        cyc_begin();
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", valid_local, 0);
        chk("rst_pkt", packet_local, 0);
        chk("rst_mis", misroute_err, 0);
        cyc_end();
        packet_east_in = 16'h0ABC; valid_east_in = 1'b1;
        cyc_begin();
        chk("t1_ready_east", ready_east_out, 1);
        chk("t1_valid_c0", valid_local, 0);
        cyc_end();
        valid_east_in = 1'b0;
        cyc_begin();
        chk("t1_valid_c1", valid_local, 1);
        chk("t1_pkt_c1", packet_local, 16'h0ABC);
        chk("t1_cnt_c1", fifo_count, 1);
        cyc_end();
        cyc_begin();
        chk("t1_cnt_hold", fifo_count, 1);
        chk("t1_pkt_hold", packet_local, 16'h0ABC);
        cyc_end();
        ready_local = 1'b1;
        cyc_begin(); cyc_end();
        ready_local = 1'b0;
        cyc_begin();
        chk("t1_cnt_drained", fifo_count, 0);
        cyc_end();

        // Round-robin with both links held valid
        do_reset();
        ready_local = 1'b1;
        packet_east_in = 16'h0111; valid_east_in = 1'b1;
        packet_west_in = 16'h0222; valid_west_in = 1'b1;
        cyc_begin();
        chk("t2_g0_east", ready_east_out, 1);
        chk("t2_g0_west", ready_west_out, 0);
        cyc_end();
        cyc_begin();
        chk("t2_g1_east", ready_east_out, 0);
        chk("t2_g1_west", ready_west_out, 1);
        chk("t2_out0", packet_local, 16'h0111);
        cyc_end();
        cyc_begin();
        chk("t2_g2_east", ready_east_out, 1);
        chk("t2_g2_west", ready_west_out, 0);
        chk("t2_out1", packet_local, 16'h0222);
        cyc_end();
        valid_east_in = 1'b0; valid_west_in = 1'b0;
        cyc_begin(); cyc_end();

        // Fill FIFO, hold fifth packet, drain with no full bypass
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            packet_east_in = 16'(i); valid_east_in = 1'b1;
            cyc_begin();
            chk("t3_fill_ready", ready_east_out, 1);
            cyc_end();
        end
        packet_east_in = 16'h0005;
        for (int i = 0; i < 2; i++) begin
            cyc_begin();
            chk("t3_full_cnt", fifo_count, 4);
            chk("t3_full_ready", ready_east_out, 0);
            cyc_end();
        end
        ready_local = 1'b1;
        cyc_begin();
        chk("t4_nobypass_ready", ready_east_out, 0);
        chk("t4_head0", packet_local, 16'h0001);
        cyc_end();
        cyc_begin();
        chk("t4_cnt3", fifo_count, 3);
        chk("t4_accept", ready_east_out, 1);
        chk("t4_head1", packet_local, 16'h0002);
        cyc_end();
        valid_east_in = 1'b0;
        cyc_begin();
        chk("t4_cnt_same", fifo_count, 3);
        chk("t4_head2", packet_local, 16'h0003);
        cyc_end();
        cyc_begin(); chk("t4_head3", packet_local, 16'h0004); cyc_end();
        cyc_begin(); chk("t4_head4", packet_local, 16'h0005); cyc_end();
        cyc_begin(); chk("t4_empty", valid_local, 0); cyc_end();

        // Misrouted west packet
        do_reset();
        ready_local = 1'b1;
        packet_west_in = 16'h3000; valid_west_in = 1'b1;
        cyc_begin();
        chk("t5_ready_west", ready_west_out, 1);
        cyc_end();
        valid_west_in = 1'b0;
        cyc_begin();
        chk("t5_mis_pulse", misroute_err, 1);
        chk("t5_cnt", fifo_count, 0);
        chk("t5_no_out", valid_local, 0);
`ifdef EJECT_STATS_EN
        chk("t5_drop_cnt", drop_cnt, 1);
`endif
        cyc_end();
        cyc_begin();
        chk("t5_mis_clear", misroute_err, 0);
        cyc_end();

        // Asynchronous reset with packets buffered
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            packet_east_in = 16'h0A00 + 16'(i); valid_east_in = 1'b1;
            cyc_begin(); cyc_end();
        end
        valid_east_in = 1'b0;
        cyc_begin();
        chk("t6_cnt3", fifo_count, 3);
        cyc_end();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", valid_local, 0);
        chk("t6_async_cnt", fifo_count, 0);
        chk("t6_async_pkt", packet_local, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        packet_east_in = 16'h0B0B; valid_east_in = 1'b1;
        packet_west_in = 16'h0C0C; valid_west_in = 1'b1;
        cyc_begin();
        chk("t6_prio_east", ready_east_out, 1);
        chk("t6_prio_west", ready_west_out, 0);
        cyc_end();
        valid_east_in = 1'b0; valid_west_in = 1'b0;
        cyc_begin(); cyc_end();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (!valid_east_in || last_xe) begin
                valid_east_in = ($urandom_range(0, 3) != 0);
                packet_east_in = rand_pkt();
            end
            if (!valid_west_in || last_xw) begin
                valid_west_in = ($urandom_range(0, 3) != 0);
                packet_west_in = rand_pkt();
            end
            case ((i / 500) % 3)
                0:       ready_local = ($urandom_range(0, 9) < 7);
                1:       ready_local = ($urandom_range(0, 9) < 2);
                default: ready_local = ($urandom_range(0, 1) == 1);
            endcase
            cyc_begin();
            chk("rand_onehot", ready_east_out & ready_west_out, 0);
            cyc_end();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
